// File: rtl/paddle_if.sv
// Paddle emulator signal bundle: board keys and core sync in, paddle comparator lines
// and positions out.
interface paddle_if;
  logic [3:0] keys;
  logic       hsync;
  logic       vsync;
  logic       hpaddle;
  logic       vpaddle;
  logic [7:0] hpos;
  logic [7:0] vpos;

  modport master (
    output keys,
    output hsync,
    output vsync,
    input  hpaddle,
    input  vpaddle,
    input  hpos,
    input  vpos
  );

  modport slave (
    input  keys,
    input  hsync,
    input  vsync,
    output hpaddle,
    output vpaddle,
    output hpos,
    output vpos
  );
endinterface

// File: rtl/paddle_emulator.sv
// Keyboard-driven paddle emulator: keys move two positions once per frame and the paddle
// lines rise once the scanline count reaches them. Optional PADDLE_ACCEL_EN adds hold accel.
module paddle_emulator #(
  parameter logic [7:0] POS_MIN  = 8'd0,
  parameter logic [7:0] POS_MAX  = 8'd239,
  parameter logic [7:0] POS_INIT = 8'd128
) (
  input logic     clk,
  input logic     reset,
  paddle_if.slave pad
);

  logic [3:0] key_meta, key_sync;
  logic       hs_d1, hs_d2, vs_d1, vs_d2;
  logic       hs_rise, vs_rise;
  logic [9:0] line_cnt, line_cnt_nxt;
  logic [7:0] hpos, hpos_nxt, vpos, vpos_nxt;
  logic       hpaddle, vpaddle;
  logic [2:0] hstep, vstep;

  // Clamping is done in 9 bits so an up/down step can never wrap the 8-bit position.
  function automatic logic [7:0] next_pos(input logic [7:0] pos, input logic up,
                                          input logic dn, input logic [2:0] step);
    logic [8:0] sum;
    logic [8:0] diff;
    sum      = {1'b0, pos} + {6'd0, step};
    diff     = {1'b0, pos} - {6'd0, step};
    next_pos = pos;
    if (up && !dn) begin
      next_pos = (sum > {1'b0, POS_MAX}) ? POS_MAX : sum[7:0];
    end else if (dn && !up) begin
      next_pos = (diff[8] || (diff[7:0] < POS_MIN)) ? POS_MIN : diff[7:0];
    end
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta <= '0;
      key_sync <= '0;
      hs_d1    <= 1'b0;
      hs_d2    <= 1'b0;
      vs_d1    <= 1'b0;
      vs_d2    <= 1'b0;
    end else begin
      key_meta <= pad.keys;
      key_sync <= key_meta;
      hs_d1    <= pad.hsync;
      hs_d2    <= hs_d1;
      vs_d1    <= pad.vsync;
      vs_d2    <= vs_d1;
    end
  end

  assign hs_rise = hs_d1 & ~hs_d2;
  assign vs_rise = vs_d1 & ~vs_d2;

  // vsync takes priority so a coincident hsync edge still starts the frame at line 0.
  always_comb begin
    line_cnt_nxt = line_cnt;
    if (vs_rise) begin
      line_cnt_nxt = '0;
    end else if (hs_rise && (line_cnt != 10'd1023)) begin
      line_cnt_nxt = line_cnt + 10'd1;
    end
  end

`ifdef PADDLE_ACCEL_EN
  logic [2:0] hcnt, hcnt_nxt, vcnt, vcnt_nxt;
  logic       hdir, hdir_nxt, vdir, vdir_nxt;

  // Returns {dir, cnt}; dir is 1 for up. A zero count marks the start of a fresh hold.
  function automatic logic [3:0] next_hold(input logic [2:0] cnt, input logic dir,
                                           input logic up, input logic dn);
    next_hold = {dir, 3'd0};
    if (up ^ dn) begin
      if (cnt == 3'd0) begin
        next_hold = {up, 3'd1};
      end else if (dir != up) begin
        next_hold = {up, 3'd0};
      end else begin
        next_hold = {dir, (cnt == 3'd7) ? 3'd7 : cnt + 3'd1};
      end
    end
  endfunction

  // Fast steps only continue an unbroken hold in the same direction.
  function automatic logic [2:0] step_for(input logic [2:0] cnt, input logic dir,
                                          input logic up);
    step_for = ((cnt == 3'd7) && (dir == up)) ? 3'd4 : 3'd1;
  endfunction

  always_comb begin
    hcnt_nxt = hcnt;
    hdir_nxt = hdir;
    vcnt_nxt = vcnt;
    vdir_nxt = vdir;
    if (vs_rise) begin
      {hdir_nxt, hcnt_nxt} = next_hold(hcnt, hdir, key_sync[1], key_sync[0]);
      {vdir_nxt, vcnt_nxt} = next_hold(vcnt, vdir, key_sync[3], key_sync[2]);
    end
  end

  assign hstep = step_for(hcnt, hdir, key_sync[1]);
  assign vstep = step_for(vcnt, vdir, key_sync[3]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      hdir <= 1'b0;
      vcnt <= '0;
      vdir <= 1'b0;
    end else begin
      hcnt <= hcnt_nxt;
      hdir <= hdir_nxt;
      vcnt <= vcnt_nxt;
      vdir <= vdir_nxt;
    end
  end
`else
  assign hstep = 3'd1;
  assign vstep = 3'd1;
`endif

  always_comb begin
    hpos_nxt = hpos;
    vpos_nxt = vpos;
    if (vs_rise) begin
      hpos_nxt = next_pos(hpos, key_sync[1], key_sync[0], hstep);
      vpos_nxt = next_pos(vpos, key_sync[3], key_sync[2], vstep);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_cnt <= '0;
      hpos     <= POS_INIT;
      vpos     <= POS_INIT;
      hpaddle  <= 1'b0;
      vpaddle  <= 1'b0;
    end else begin
      line_cnt <= line_cnt_nxt;
      hpos     <= hpos_nxt;
      vpos     <= vpos_nxt;
      hpaddle  <= (line_cnt >= {2'b00, hpos});
      vpaddle  <= (line_cnt >= {2'b00, vpos});
    end
  end

  assign pad.hpaddle = hpaddle;
  assign pad.vpaddle = vpaddle;
  assign pad.hpos    = hpos;
  assign pad.vpos    = vpos;

endmodule

// File: tb/tb_paddle_emulator.sv
// Directed bench for paddle_emulator: line timing, key stepping, clamping, sync priority,
// asynchronous reset and line-counter saturation.
module tb_paddle_emulator;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  paddle_if pad ();

  paddle_emulator dut (
    .clk  (clk),
    .reset(reset),
    .pad  (pad)
  );

  always #5 clk = ~clk;

`ifdef PADDLE_ACCEL_EN
  localparam int DownFrames = 20;
  localparam int DownPos    = 180;
`else
  localparam int DownFrames = 189;
  localparam int DownPos    = 50;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hpulses(input int n);
    for (int i = 0; i < n; i++) begin
      pad.hsync = 1'b1;
      repeat (3) tick();
      pad.hsync = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic vpulses(input int n);
    for (int i = 0; i < n; i++) begin
      pad.vsync = 1'b1;
      repeat (3) tick();
      pad.vsync = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic set_keys(input logic [3:0] k);
    pad.keys = k;
    repeat (4) tick();
  endtask

  initial begin
    reset     = 1'b1;
    pad.keys  = 4'b0000;
    pad.hsync = 1'b0;
    pad.vsync = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    check("reset_hpaddle", 32'(pad.hpaddle), 0);
    check("reset_vpaddle", 32'(pad.vpaddle), 0);
    check("reset_hpos", 32'(pad.hpos), 128);
    check("reset_vpos", 32'(pad.vpos), 128);

    // Line timing within one frame: paddles stay low through line 127.
    vpulses(1);
    hpulses(127);
    check("line127_hpaddle", 32'(pad.hpaddle), 0);
    check("line127_vpaddle", 32'(pad.vpaddle), 0);
    pad.hsync = 1'b1;
    tick();
    check("h128_edge_n", 32'(pad.hpaddle), 0);
    tick();
    check("h128_edge_n1", 32'(pad.hpaddle), 0);
    tick();
    check("h128_edge_n2", 32'(pad.hpaddle), 1);
    check("v128_edge_n2", 32'(pad.vpaddle), 1);
    pad.hsync = 1'b0;
    repeat (3) tick();
    vpulses(1);
    check("newframe_hpaddle", 32'(pad.hpaddle), 0);
    vpulses(9);
    check("idle_hpos", 32'(pad.hpos), 128);
    check("idle_vpos", 32'(pad.vpos), 128);

    // One step per vsync edge even with 3-cycle-wide pulses.
    set_keys(4'b0010);
    vpulses(5);
    check("hup5_hpos", 32'(pad.hpos), 133);
    check("hup5_vpos", 32'(pad.vpos), 128);

    set_keys(4'b0011);
    vpulses(4);
    check("hboth_hpos", 32'(pad.hpos), 133);
    set_keys(4'b1100);
    vpulses(4);
    check("vboth_vpos", 32'(pad.vpos), 128);

    set_keys(4'b0100);
    vpulses(200);
    check("vdown_floor_vpos", 32'(pad.vpos), 0);
    check("vdown_hpos", 32'(pad.hpos), 133);

    set_keys(4'b0010);
    vpulses(120);
    check("hup_ceiling", 32'(pad.hpos), 239);
    set_keys(4'b0001);
    vpulses(1);
    check("hdown_238", 32'(pad.hpos), 238);
    set_keys(4'b0010);
    vpulses(1);
    check("hup_239", 32'(pad.hpos), 239);
    vpulses(2);
    check("hup_hold_239", 32'(pad.hpos), 239);
    set_keys(4'b0000);

    // Coincident hsync/vsync edges: vsync wins and the line count restarts.
    vpulses(1);
    hpulses(240);
    check("line240_hpaddle", 32'(pad.hpaddle), 1);
    pad.hsync = 1'b1;
    pad.vsync = 1'b1;
    tick();
    tick();
    check("both_edge_n1", 32'(pad.hpaddle), 1);
    tick();
    check("both_edge_n2", 32'(pad.hpaddle), 0);
    check("both_line_cnt", 32'(dut.line_cnt), 0);
    pad.hsync = 1'b0;
    pad.vsync = 1'b0;
    repeat (3) tick();

    // Asynchronous reset mid-frame.
    set_keys(4'b0001);
    vpulses(DownFrames);
    check("pre_reset_hpos", 32'(pad.hpos), 32'(DownPos));
    set_keys(4'b0000);
    hpulses(200);
    check("pre_reset_hpaddle", 32'(pad.hpaddle), 1);
    check("pre_reset_vpaddle", 32'(pad.vpaddle), 1);
    reset = 1'b1;
    #2;
    check("async_hpaddle", 32'(pad.hpaddle), 0);
    check("async_vpaddle", 32'(pad.vpaddle), 0);
    check("async_hpos", 32'(pad.hpos), 128);
    check("async_vpos", 32'(pad.vpos), 128);
    tick();
    reset = 1'b0;

    // Counting resumes without a vsync and saturates at 1023.
    hpulses(100);
    check("post_reset_line_cnt", 32'(dut.line_cnt), 100);
    check("post_reset_hpaddle", 32'(pad.hpaddle), 0);
    hpulses(1000);
    check("sat_line_cnt", 32'(dut.line_cnt), 1023);
    check("sat_hpaddle", 32'(pad.hpaddle), 1);
    check("sat_vpos", 32'(pad.vpos), 128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
